// File: rtl/count_sequencer.sv
// count_sequencer
//   Drives the select input of a 3-bit seven-segment decoder. The board clock
//   is divided down to a step tick of DIV cycles. On each step a wrap-around
//   3-bit counter moves up or down. A push-button edge toggles run/pause, and
//   a synchronous load writes the count directly. Every output comes straight
//   from a flop, so the decoder never sees a glitch.
//
// Ports
//   clk        board clock, rising-edge
//   reset      synchronous, active-high; overrides everything
//   start_stop raw (externally debounced) button level, async to clk
//   up         1 = count up, 0 = count down; only looked at on step cycles
//   load       level-sensitive load strobe, takes priority over stepping
//   load_val   value written to count while load is high
//   count      current count
//   run        1 = RUN, 0 = PAUSE
//   tick       one-cycle pulse aligned with each newly stepped count
//   wrap       one-cycle pulse aligned with a 7->0 (up) or 0->7 (down) step
module count_sequencer #(
    parameter int DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       up,
    input  logic       load,
    input  logic [2:0] load_val,
    output logic [2:0] count,
    output logic       run,
    output logic       tick,
    output logic       wrap
);

    localparam int            DW   = $clog2(DIV);
    localparam logic [DW-1:0] LAST = DW'(DIV - 1);

    typedef enum logic {
        PAUSE = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t        state, state_next;
    logic          s1, s2, s3;
    logic          press;
    logic          step;
    logic [DW-1:0] div_cnt;

    // s1/s2 synchronize the button; s3 holds the previous synchronized level
    // so a held button yields a single press.
    assign press = s2 & ~s3;

    // A step uses the current state, so a press landing on a step edge still
    // lets that step happen while run drops on the same edge.
    assign step = (state == RUN) && (div_cnt == LAST) && !load;

    assign run = (state == RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= PAUSE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (press) begin
            state_next = (state == RUN) ? PAUSE : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= start_stop;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= 3'd0;
            div_cnt <= '0;
            tick    <= 1'b0;
            wrap    <= 1'b0;
        end else if (load) begin
            // Restarting the prescaler makes the next step a full interval
            // after load is released.
            count   <= load_val;
            div_cnt <= '0;
            tick    <= 1'b0;
            wrap    <= 1'b0;
        end else if (step) begin
            count   <= up ? count + 3'd1 : count - 3'd1;
            div_cnt <= '0;
            tick    <= 1'b1;
            wrap    <= up ? (count == 3'd7) : (count == 3'd0);
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
            // Paused: hold the partial interval so a resume finishes it.
            if (state == RUN) begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer with DIV=4: directed scenarios with constant
// expectations, then a randomized run checked cycle by cycle against a
// behavioural model kept in this file.
module tb_count_sequencer;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_stop;
    logic       up;
    logic       load;
    logic [2:0] load_val;
    logic [2:0] count;
    logic       run;
    logic       tick;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    count_sequencer #(.DIV(DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .start_stop(start_stop),
        .up        (up),
        .load      (load),
        .load_val  (load_val),
        .count     (count),
        .run       (run),
        .tick      (tick),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    // Behavioural model: run toggles two edges after the button is first seen
    // high (level history of sampled button values); a step happens once DIV
    // RUN cycles have elapsed since the last step/load/reset.
    logic [2:0] m_count;
    logic       m_run, m_tick, m_wrap;
    int         m_elapsed;
    logic       hist [0:2];   // button level sampled 1, 2 and 3 edges ago

    always @(posedge clk) begin : model
        int nc;
        logic pressed;
        if (reset) begin
            m_count   <= 3'd0;
            m_run     <= 1'b0;
            m_tick    <= 1'b0;
            m_wrap    <= 1'b0;
            m_elapsed <= 0;
            hist[0]   <= 1'b0;
            hist[1]   <= 1'b0;
            hist[2]   <= 1'b0;
        end else begin
            pressed = hist[1] && !hist[2];
            hist[0] <= start_stop;
            hist[1] <= hist[0];
            hist[2] <= hist[1];
            if (pressed) m_run <= !m_run;
            if (load) begin
                m_count   <= load_val;
                m_elapsed <= 0;
                m_tick    <= 1'b0;
                m_wrap    <= 1'b0;
            end else if (m_run && m_elapsed == DIV - 1) begin
                nc = up ? (int'(m_count) + 1) % 8 : (int'(m_count) + 7) % 8;
                m_count   <= 3'(nc);
                m_tick    <= 1'b1;
                m_wrap    <= up ? (m_count == 3'd7) : (m_count == 3'd0);
                m_elapsed <= 0;
            end else begin
                m_tick <= 1'b0;
                m_wrap <= 1'b0;
                if (m_run) m_elapsed <= m_elapsed + 1;
            end
        end
    end

    task automatic step_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start_stop = 1'b1; load = 1'b1; load_val = 3'd5; up = 1'b1;
        step_edge();
        step_edge();
        checks++;
        if ({count, run, tick, wrap} !== 6'b0) begin
            errors++;
            $display("FAIL reset_values: got count=%0d run=%b tick=%b wrap=%b, want all 0",
                     count, run, tick, wrap);
        end
        reset = 1'b0; start_stop = 1'b0; load = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step_edge();
            checks++;
            if ({count, run, tick, wrap} !== 6'b0) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: got count=%0d run=%b tick=%b wrap=%b, want all 0",
                         i, count, run, tick, wrap);
            end
        end
    endtask

    task automatic test_run_up();
        up = 1'b1;
        start_stop = 1'b1;
        step_edge();
        start_stop = 1'b0;
        for (int e = 0; e < 3; e++) begin
            if (e > 0) step_edge();
            checks++;
            if (run !== (e == 2)) begin
                errors++;
                $display("FAIL run_latency edge %0d: got run=%b, want %b", e, run, e == 2);
            end
        end
        for (int k = 1; k <= 8; k++) begin
            for (int j = 1; j <= DIV; j++) begin
                step_edge();
                checks++;
                if (j < DIV) begin
                    if ({count, tick, wrap} !== {3'((k - 1) % 8), 2'b00}) begin
                        errors++;
                        $display("FAIL up_hold k=%0d j=%0d: got count=%0d tick=%b wrap=%b, want count=%0d tick=0 wrap=0",
                                 k, j, count, tick, wrap, (k - 1) % 8);
                    end
                end else begin
                    if ({count, tick, wrap} !== {3'(k % 8), 1'b1, k == 8}) begin
                        errors++;
                        $display("FAIL up_step k=%0d: got count=%0d tick=%b wrap=%b, want count=%0d tick=1 wrap=%b",
                                 k, count, tick, wrap, k % 8, k == 8);
                    end
                end
            end
        end
    endtask

    task automatic test_down();
        logic [2:0] want [0:1];
        want[0] = 3'd7;
        want[1] = 3'd6;
        up = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int j = 1; j <= DIV; j++) begin
                step_edge();
                checks++;
                if (j == DIV) begin
                    if ({count, tick, wrap} !== {want[k], 1'b1, k == 0}) begin
                        errors++;
                        $display("FAIL down_step %0d: got count=%0d tick=%b wrap=%b, want count=%0d tick=1 wrap=%b",
                                 k, count, tick, wrap, want[k], k == 0);
                    end
                end else if (tick !== 1'b0 || wrap !== 1'b0) begin
                    errors++;
                    $display("FAIL down_hold %0d: got tick=%b wrap=%b, want 0 0", k, tick, wrap);
                end
            end
        end
    endtask

    // Enters with count=6, interval just restarted. Pause lands with two
    // cycles of the interval used; resume must finish in two more.
    task automatic test_pause();
        for (int i = 0; i < 3; i++) step_edge();
        start_stop = 1'b1;
        step_edge();
        checks++;
        if ({count, run, tick} !== {3'd5, 2'b11}) begin
            errors++;
            $display("FAIL pause_prestep: got count=%0d run=%b tick=%b, want 5 1 1", count, run, tick);
        end
        step_edge();
        step_edge();
        checks++;
        if ({count, run, tick} !== {3'd5, 2'b00}) begin
            errors++;
            $display("FAIL pause_enter: got count=%0d run=%b tick=%b, want 5 0 0", count, run, tick);
        end
        start_stop = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step_edge();
            checks++;
            if ({count, run, tick} !== {3'd5, 2'b00}) begin
                errors++;
                $display("FAIL pause_frozen cyc %0d: got count=%0d run=%b tick=%b, want 5 0 0",
                         i, count, run, tick);
            end
        end
        start_stop = 1'b1;
        step_edge();
        step_edge();
        step_edge();
        start_stop = 1'b0;
        checks++;
        if ({count, run, tick} !== {3'd5, 2'b10}) begin
            errors++;
            $display("FAIL resume: got count=%0d run=%b tick=%b, want 5 1 0", count, run, tick);
        end
        step_edge();
        checks++;
        if (tick !== 1'b0) begin
            errors++;
            $display("FAIL resume_early: got tick=%b, want 0", tick);
        end
        step_edge();
        checks++;
        if ({count, tick, wrap} !== {3'd4, 2'b10}) begin
            errors++;
            $display("FAIL resume_step: got count=%0d tick=%b wrap=%b, want 4 1 0", count, tick, wrap);
        end
    endtask

    task automatic test_load();
        for (int i = 0; i < 3; i++) step_edge();
        load = 1'b1; load_val = 3'd5;
        step_edge();
        checks++;
        if ({count, run, tick, wrap} !== {3'd5, 3'b100}) begin
            errors++;
            $display("FAIL load_prio: got count=%0d run=%b tick=%b wrap=%b, want 5 1 0 0",
                     count, run, tick, wrap);
        end
        load = 1'b0; load_val = 3'd2; up = 1'b1;
        for (int j = 1; j <= DIV; j++) begin
            step_edge();
            checks++;
            if (j < DIV) begin
                if ({count, tick} !== {3'd5, 1'b0}) begin
                    errors++;
                    $display("FAIL load_hold j=%0d: got count=%0d tick=%b, want 5 0", j, count, tick);
                end
            end else if ({count, tick, wrap} !== {3'd6, 2'b10}) begin
                errors++;
                $display("FAIL load_next_step: got count=%0d tick=%b wrap=%b, want 6 1 0",
                         count, tick, wrap);
            end
        end
    endtask

    task automatic test_reset_mid();
        start_stop = 1'b1;
        step_edge();
        reset = 1'b1; start_stop = 1'b0;
        step_edge();
        checks++;
        if ({count, run, tick, wrap} !== 6'b0) begin
            errors++;
            $display("FAIL reset_mid: got count=%0d run=%b tick=%b wrap=%b, want all 0",
                     count, run, tick, wrap);
        end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step_edge();
            checks++;
            if ({count, run} !== 4'b0) begin
                errors++;
                $display("FAIL reset_mid_after cyc %0d: got count=%0d run=%b, want 0 0", i, count, run);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) start_stop = ~start_stop;
            up       = 1'($urandom_range(1));
            load     = ($urandom_range(15) == 0);
            load_val = 3'($urandom_range(7));
            step_edge();
            checks++;
            if ({count, run, tick, wrap} !== {m_count, m_run, m_tick, m_wrap}) begin
                errors++;
                $display("FAIL random cyc %0d: got count=%0d run=%b tick=%b wrap=%b, want count=%0d run=%b tick=%b wrap=%b",
                         i, count, run, tick, wrap, m_count, m_run, m_tick, m_wrap);
            end
        end
    endtask

    initial begin
        test_reset();
        test_run_up();
        test_down();
        test_pause();
        test_load();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
